// File: rtl/arg_serializer.sv
// arg_serializer: formats one signed argument as "<title>[-]<digits><sep>" and
// hands it, one character per write handshake, to a downstream character writer.
module arg_serializer #(
    parameter int          NUM_BITS = 16,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                trigger,
    input  logic [7:0]          arg_title,
    input  logic [NUM_BITS-1:0] num,
    output logic                rdy,
    output logic                done,
    output logic [7:0]          char_out,
    output logic                wr_trigger,
    input  logic                wr_rdy,
    input  logic                wr_done,
    input  logic                is_full
);
    localparam int DIGITS = (NUM_BITS*3+9)/10;
    localparam int BW     = 4*DIGITS;
    localparam int DW     = $clog2(DIGITS);
    localparam int CW     = $clog2(NUM_BITS+1);

    typedef enum logic [2:0] {IDLE, LOAD, CONVERT, SEND, WAIT_WR, DONE} state_t;
    typedef enum logic [1:0] {C_TITLE, C_SIGN, C_DIGIT, C_SEP} chr_t;

    state_t              state, state_nx;
    chr_t                idx;
    logic [7:0]          title, char_cur;
    logic [NUM_BITS-1:0] num_r, mag, mag_nx;
    logic [BW-1:0]       bcd, bcd_adj, bcd_nx;
    logic [CW-1:0]       cnt;
    logic [DW-1:0]       dig, top;
    logic [3:0]          nib;
    logic                neg, go;

    assign go = wr_rdy && !is_full;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    assign {bcd_nx, mag_nx} = {bcd_adj, mag} << 1;

    // highest non-zero nibble of the finished conversion; zero yields nibble 0
    always_comb begin
        top = '0;
        for (int j = 0; j < DIGITS; j++)
            if (bcd_nx[4*j +: 4] != 4'd0) top = DW'(j);
    end

    assign nib      = bcd[{dig, 2'b00} +: 4];
    assign char_cur = idx == C_TITLE ? title :
                      idx == C_SIGN  ? 8'h2D :
                      idx == C_DIGIT ? {4'h3, nib} : SEP_CHAR;

    assign rdy        = !reset && state == IDLE;
    assign done       = !reset && state == DONE;
    assign wr_trigger = !reset && state == SEND && go;
    assign char_out   = (state == SEND || state == WAIT_WR) ? char_cur : 8'h00;

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else if (clk_en) state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = trigger ? LOAD : IDLE;
            LOAD:    state_nx = CONVERT;
            CONVERT: state_nx = cnt == CW'(1) ? SEND : CONVERT;
            SEND:    state_nx = go ? WAIT_WR : SEND;
            WAIT_WR: state_nx = !wr_done ? WAIT_WR : idx == C_SEP ? DONE : SEND;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            title <= '0;
            num_r <= '0;
            neg   <= 1'b0;
            mag   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            dig   <= '0;
            idx   <= C_TITLE;
        end else if (clk_en) begin
            case (state)
                IDLE: if (trigger) begin
                    title <= arg_title;
                    num_r <= num;
                end
                LOAD: begin
                    neg <= num_r[NUM_BITS-1];
                    mag <= num_r[NUM_BITS-1] ? -num_r : num_r;
                    bcd <= '0;
                    cnt <= CW'(NUM_BITS);
                    idx <= C_TITLE;
                end
                CONVERT: begin
                    bcd <= bcd_nx;
                    mag <= mag_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) dig <= top;
                end
                WAIT_WR: if (wr_done)
                    case (idx)
                        C_TITLE: idx <= neg ? C_SIGN : C_DIGIT;
                        C_SIGN:  idx <= C_DIGIT;
                        C_DIGIT: if (dig == '0) idx <= C_SEP;
                                 else dig <= dig - 1'b1;
                        default: ;
                    endcase
                default: ;
            endcase
        end
endmodule

// File: tb/tb_arg_serializer.sv
// tb_arg_serializer: directed tokens through arg_serializer with a one-cycle writer model.
module tb_arg_serializer;
    logic        clk = 1'b0, reset = 1'b1, clk_en = 1'b1, trigger = 1'b0;
    logic        wr_rdy = 1'b1, is_full = 1'b0, spur = 1'b0, wr_done_r = 1'b0, en_mode = 1'b0;
    logic [7:0]  arg_title = 8'h00;
    logic [15:0] num = 16'h0000;
    logic        rdy, done, wr_trigger, wr_done;
    logic [7:0]  char_out;
    logic [7:0]  got[$];
    int total = 0, bad = 0, done_cnt = 0, full_viol = 0, pulse_viol = 0;
    int cyc = 0, t_acc = 0, t_done = 0, ph = 0, g0 = 0, d0 = 0;
    logic prev_wt = 1'b0, prev_done = 1'b0;

    assign wr_done = wr_done_r | spur;

    arg_serializer #(.NUM_BITS(16), .SEP_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
        .arg_title(arg_title), .num(num), .rdy(rdy), .done(done),
        .char_out(char_out), .wr_trigger(wr_trigger), .wr_rdy(wr_rdy),
        .wr_done(wr_done), .is_full(is_full)
    );

    always #5 clk = ~clk;

    // writer model and monitors, evaluated on enabled edges only
    initial forever begin
        @(posedge clk);
        if (clk_en) begin
            wr_done_r <= wr_trigger;
            if (!reset) begin
                cyc = cyc + 1;
                if (wr_trigger) got.push_back(char_out);
                if (wr_trigger && is_full) full_viol = full_viol + 1;
                if ((wr_trigger && prev_wt) || (done && prev_done)) pulse_viol = pulse_viol + 1;
                if (trigger && rdy) t_acc = cyc;
                if (done) begin
                    done_cnt = done_cnt + 1;
                    t_done = cyc;
                end
                prev_wt = wr_trigger;
                prev_done = done;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        ph = (ph + 1) % 3;
        clk_en = en_mode ? (ph == 0) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [63:0] pack_s(input string s);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < s.len(); i++) v = (v << 8) | 64'(s[i]);
        return v;
    endfunction

    function automatic logic [63:0] pack_q();
        logic [63:0] v = 64'd0;
        for (int i = g0; i < got.size(); i++) v = (v << 8) | 64'(got[i]);
        return v;
    endfunction

    task automatic start(input logic [7:0] t, input logic [15:0] n);
        int k = 0;
        while (!rdy && k < 500) begin @(negedge clk); k++; end
        g0 = got.size();
        d0 = done_cnt;
        arg_title = t;
        num = n;
        trigger = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (rdy && k < 500);
        trigger = 1'b0;
        arg_title = 8'h41;
        num = 16'h1234;
        check("accept", 64'(rdy), 64'd0);
    endtask

    task automatic finish(input string tag, input string exp);
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin @(negedge clk); k++; end
        repeat (6) @(negedge clk);
        check({tag, "_str"}, pack_q(), pack_s(exp));
        check({tag, "_len"}, 64'(got.size() - g0), 64'(exp.len()));
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wt", 64'(wr_trigger), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rdy", 64'(rdy), 64'd1);
        check("post_char", 64'(char_out), 64'd0);

        start(8'h58, 16'd123);
        finish("x123", "X123 ");
        check("x123_cycles", 64'(t_done - t_acc + 1), 64'd29);

        start(8'h59, 16'hFFD3);
        repeat (3) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        finish("y_m45", "Y-45 ");

        start(8'h46, 16'd0);
        finish("f0", "F0 ");

        start(8'h58, 16'h8000);
        finish("xmin", "X-32768 ");

        start(8'h58, 16'd123);
        k = 0;
        while (got.size() < g0 + 1 && k < 500) begin @(negedge clk); k++; end
        is_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) check("full_wt", 64'(wr_trigger), 64'd0);
            if (i == 3 || i == 9) check("full_char", 64'(char_out), 64'h31);
        end
        check("full_count", 64'(got.size() - g0), 64'd1);
        is_full = 1'b0;
        finish("full", "X123 ");
        check("full_viol", 64'(full_viol), 64'd0);

        en_mode = 1'b1;
        start(8'h5A, 16'hFCDF);
        arg_title = 8'h51;
        num = 16'd999;
        trigger = 1'b1;
        repeat (6) @(negedge clk);
        trigger = 1'b0;
        finish("clken", "Z-801 ");
        check("pulse_viol", 64'(pulse_viol), 64'd0);
        en_mode = 1'b0;
        repeat (3) @(negedge clk);

        start(8'h58, 16'd123);
        k = 0;
        while (got.size() < g0 + 2 && k < 500) begin @(negedge clk); k++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rdy", 64'(rdy), 64'd1);
        repeat (20) @(negedge clk);
        check("abort_writes", 64'(got.size() - g0), 64'd2);
        check("abort_done", 64'(done_cnt - d0), 64'd0);
        start(8'h58, 16'd7);
        finish("x7", "X7 ");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
